freq_meter: RTL and testbench
=============================

Name: freq_meter

Overview:
Gated frequency counter that produces the 24-bit per-channel frequency words consumed by the soft-processor core's freq_N inputs. One instance per channel; eight in the top level.
Counts rising edges of an asynchronous input over a fixed gate window of clk_clk cycles, then latches the count into a held output register.
Runs in back-to-back windows while enabled. The output updates once per window, with a one-cycle valid strobe.

Parameters:
GATE_CYCLES, 50000000, gate window length in clk_clk cycles (1 s at 50 MHz); must be >= 2
CNT_W, 24, width of edge counter and freq_out
SYNC_STAGES, 2, input synchronizer depth; must be >= 2

Ports:
clk_clk  input  1  system clock
reset_reset_n  input  1  synchronous active-low reset
enable  input  1  run measurement windows while high
sig_in  input  1  asynchronous signal to measure
freq_out  output  CNT_W  edge count of last completed window, held between updates
freq_valid  output  1  one-cycle pulse when freq_out updates
overflow  output  1  last completed window saturated; updates with freq_out
busy  output  1  high while in MEASURE

Behaviour:
- Reset is synchronous on the rising edge of clk_clk with reset_reset_n low.
  - freq_out=0, freq_valid=0, overflow=0, busy=0.
  - Synchronizer cleared to 0; gate_cnt=0; edge_cnt=0; state=IDLE.
- Reset mid-window aborts the window. freq_out is cleared and no valid pulse is issued.
- sig_in passes through SYNC_STAGES flops. An edge is registered when the last stage is 1 and the previous sample of that stage was 0.
  - Edge-to-count latency is SYNC_STAGES+1 cycles.
  - Input pulses shorter than one clock may be missed; this is accepted.
- States: IDLE, MEASURE.
  - IDLE: busy=0; gate_cnt and edge_cnt held at 0.
    - enable=1 moves to MEASURE on the next edge.
    - The edge-detect history register keeps tracking in IDLE, so the first MEASURE cycle raises no false edge.
  - MEASURE: busy=1; gate_cnt increments every cycle.
    - edge_cnt increments on each detected edge.
    - edge_cnt saturates at 2^CNT_W-1; further edges set the internal ovf_win flag.
- Window end (MEASURE and gate_cnt==GATE_CYCLES-1):
  - freq_out <= sat(edge_cnt + edge_this_cycle).
  - overflow <= ovf_win, or 1 if that addition saturates.
  - freq_valid <= 1 for exactly one cycle, asserted the cycle after the window's last cycle, coincident with new freq_out.
  - gate_cnt, edge_cnt and ovf_win clear to 0.
  - Stays in MEASURE if enable=1 (no dead cycle between windows); otherwise goes to IDLE.
- enable falling mid-window: return to IDLE next cycle and discard the partial count.
  - freq_out and overflow hold their last values; no freq_valid.
- enable falling on the window-end cycle: the window completes and publishes normally, then IDLE.
- An edge on the final cycle of a window counts in that window. An edge on the first cycle of the next window counts in the next.
- Each window is exactly GATE_CYCLES cycles; freq_valid pulses are exactly GATE_CYCLES apart during continuous operation.
- gate_cnt width is $clog2(GATE_CYCLES). All arithmetic is unsigned; saturation is via a CNT_W+1-bit sum compared against the all-ones value.

Optional Feature:
FREQ_METER_AVG_EN
- Defined:
  - A 4-entry history of raw window results is kept.
  - freq_out = (sum of the last 4 raw results) >> 2, using a CNT_W+2-bit accumulator, truncated.
  - Before 4 windows have completed since reset or since leaving IDLE, empty entries are 0, so the output ramps up.
  - History is cleared on entering MEASURE from IDLE.
  - overflow = OR of the 4 entries' overflow bits.
  - freq_valid timing is unchanged.
- Undefined: freq_out is the raw window count as described in Behaviour; no history registers are synthesized.

Decomposition:
- Package freq_meter_pkg:
  - state enum typedef {IDLE, MEASURE}.
  - Localparam CNT_MAX = 2^CNT_W-1 helper.
  - AVG_DEPTH=4 constant.
- One natural sub-module, sync_edge_det: SYNC_STAGES synchronizer plus rising-edge pulse. It is reused for other asynchronous inputs (e.g. the uart rxd line).

Test Plan:
1. GATE_CYCLES=100; enable=1; sig_in toggling every 5 cycles (period 10), steady state → freq_out=10, freq_valid pulses every 100 cycles, overflow=0.
2. CNT_W=4, GATE_CYCLES=100; sig_in period 4 (25 edges) → freq_out=15, overflow=1. Next window with sig_in=0 → freq_out=0, overflow=0.
3. enable dropped at gate_cnt=50 after freq_out=10 → IDLE, no freq_valid, freq_out stays 10. Re-enable → the next pulse comes 100 cycles after the first MEASURE cycle.
4. reset_reset_n low for 1 cycle at gate_cnt=70 → all outputs 0 next cycle. Window restarts only when enable is high, from gate_cnt=0.
5. Edge forced to be detected on the gate_cnt=99 cycle → counted in the current window; the edge one cycle later counts in the next.
6. FREQ_METER_AVG_EN defined; window results 8, 8, 8, 8 → freq_out sequence 2, 4, 6, 8.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared types and constants for the gated frequency meter.
//   state_e       : measurement FSM states (IDLE, MEASURE)
//   CNT_W_DEFAULT : default counter width used by the top level
//   CNT_MAX       : saturation value of a default-width counter
//   AVG_DEPTH     : number of window results combined by the optional
//                   averaging build (FREQ_METER_AVG_EN)
package freq_meter_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

  localparam int CNT_W_DEFAULT = 24;
  localparam logic [CNT_W_DEFAULT-1:0] CNT_MAX = {CNT_W_DEFAULT{1'b1}};
  localparam int AVG_DEPTH = 4;

endpackage

// File: rtl/freq_meter_sync_edge_det.sv
// sync_edge_det: multi-flop synchronizer for an asynchronous input followed
// by a rising-edge detector. Reusable for any asynchronous line.
//   clk    : sampling clock
//   rst_n  : synchronous active-low reset (clears synchronizer and history)
//   d_in   : asynchronous input
//   rise   : high for one cycle when the synchronized input goes 0 -> 1
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   hist_q;
  logic                   hist_d;

  // Next-state for the synchronizer chain and the edge-history flop.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  // Synchronizer and history registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  // History runs continuously, so enabling a consumer never sees a stale edge.
  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/freq_meter.sv
// freq_meter: gated frequency counter. Counts rising edges of sig_in over
// back-to-back windows of GATE_CYCLES clocks and publishes each window's
// count on freq_out with a one-cycle freq_valid strobe.
//   clk_clk       : system clock
//   reset_reset_n : synchronous active-low reset
//   enable        : run measurement windows while high
//   sig_in        : asynchronous signal to measure
//   freq_out      : count of the last completed window (held)
//   freq_valid    : one-cycle pulse when freq_out updates
//   overflow      : last completed window saturated
//   busy          : high while in MEASURE
// Build option: define FREQ_METER_AVG_EN to publish the truncated mean of the
// last AVG_DEPTH window results instead of the raw count.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 50000000,
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_out,
  output logic             freq_valid,
  output logic             overflow,
  output logic             busy
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]  GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W:0] MAX_EXT   = {1'b0, {CNT_W{1'b1}}};

  state_e           state_q,      state_d;
  logic [GW-1:0]    gate_cnt_q,   gate_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q,   edge_cnt_d;
  logic             ovf_win_q,    ovf_win_d;
  logic [CNT_W-1:0] freq_out_q,   freq_out_d;
  logic             freq_valid_q, freq_valid_d;
  logic             overflow_q,   overflow_d;

  logic             edge_rise_s;
  logic [CNT_W:0]   edge_sum_s;
  logic             edge_sat_s;
  logic [CNT_W-1:0] raw_cnt_s;
  logic             raw_ovf_s;
  logic             window_end_s;
  logic [CNT_W-1:0] pub_cnt_s;
  logic             pub_ovf_s;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .d_in  (sig_in),
    .rise  (edge_rise_s)
  );

  // Saturating edge accumulation; the extra sum bit exposes the carry-out.
  always_comb begin
    edge_sum_s   = {1'b0, edge_cnt_q} + {{CNT_W{1'b0}}, edge_rise_s};
    edge_sat_s   = (edge_sum_s > MAX_EXT);
    if (edge_sat_s) begin
      raw_cnt_s = MAX_EXT[CNT_W-1:0];
    end else begin
      raw_cnt_s = edge_sum_s[CNT_W-1:0];
    end
    raw_ovf_s    = ovf_win_q | edge_sat_s;
    window_end_s = (state_q == MEASURE) && (gate_cnt_q == GATE_LAST);
  end

`ifdef FREQ_METER_AVG_EN
  // The newest result is raw_cnt_s itself, so only the previous
  // AVG_DEPTH-1 results need storage.
  localparam int HIST_N = AVG_DEPTH - 1;

  logic [CNT_W-1:0]  hist_cnt_q [HIST_N];
  logic [CNT_W-1:0]  hist_cnt_d [HIST_N];
  logic [HIST_N-1:0] hist_ovf_q;
  logic [HIST_N-1:0] hist_ovf_d;
  logic [CNT_W+1:0]  acc_s;
  logic              hist_clr_s;

  // Averaged publish value and history shift on window end.
  always_comb begin
    hist_clr_s = (state_q == IDLE) && enable;
    acc_s      = {2'b00, raw_cnt_s};
    pub_ovf_s  = raw_ovf_s;
    for (int i = 0; i < HIST_N; i++) begin
      acc_s     = acc_s + {2'b00, hist_cnt_q[i]};
      pub_ovf_s = pub_ovf_s | hist_ovf_q[i];
    end
    pub_cnt_s = acc_s[CNT_W+1:2];

    hist_cnt_d = hist_cnt_q;
    hist_ovf_d = hist_ovf_q;
    if (hist_clr_s) begin
      for (int i = 0; i < HIST_N; i++) begin
        hist_cnt_d[i] = '0;
      end
      hist_ovf_d = '0;
    end else if (window_end_s) begin
      hist_cnt_d[0] = raw_cnt_s;
      hist_ovf_d[0] = raw_ovf_s;
      for (int i = 1; i < HIST_N; i++) begin
        hist_cnt_d[i] = hist_cnt_q[i-1];
        hist_ovf_d[i] = hist_ovf_q[i-1];
      end
    end else begin
      hist_ovf_d = hist_ovf_q;
    end
  end

  // History registers with synchronous reset.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < HIST_N; i++) begin
        hist_cnt_q[i] <= '0;
      end
      hist_ovf_q <= '0;
    end else begin
      hist_cnt_q <= hist_cnt_d;
      hist_ovf_q <= hist_ovf_d;
    end
  end
`else
  assign pub_cnt_s = raw_cnt_s;
  assign pub_ovf_s = raw_ovf_s;
`endif

  // FSM next state, window counters and published outputs.
  always_comb begin
    state_d      = state_q;
    gate_cnt_d   = gate_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    ovf_win_d    = ovf_win_q;
    freq_out_d   = freq_out_q;
    overflow_d   = overflow_q;
    freq_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        ovf_win_d  = 1'b0;
        if (enable) begin
          state_d = MEASURE;
        end else begin
          state_d = IDLE;
        end
      end
      MEASURE: begin
        if (window_end_s) begin
          // The final cycle's edge is folded in via raw_cnt_s.
          freq_out_d   = pub_cnt_s;
          overflow_d   = pub_ovf_s;
          freq_valid_d = 1'b1;
          gate_cnt_d   = '0;
          edge_cnt_d   = '0;
          ovf_win_d    = 1'b0;
          if (enable) begin
            state_d = MEASURE;
          end else begin
            state_d = IDLE;
          end
        end else if (!enable) begin
          // Partial window is discarded; published outputs hold.
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          ovf_win_d  = 1'b0;
          state_d    = IDLE;
        end else begin
          gate_cnt_d = gate_cnt_q + GW'(1'b1);
          edge_cnt_d = raw_cnt_s;
          ovf_win_d  = raw_ovf_s;
        end
      end
      default: begin
        state_d    = IDLE;
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        ovf_win_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q      <= IDLE;
      gate_cnt_q   <= '0;
      edge_cnt_q   <= '0;
      ovf_win_q    <= 1'b0;
      freq_out_q   <= '0;
      freq_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      gate_cnt_q   <= gate_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      ovf_win_q    <= ovf_win_d;
      freq_out_q   <= freq_out_d;
      freq_valid_q <= freq_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  assign freq_out   = freq_out_q;
  assign freq_valid = freq_valid_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q == MEASURE);

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: randomized scoreboard bench for freq_meter with a short
// window (100 cycles) and a 4-bit counter so saturation is reachable.
module tb_freq_meter;

  localparam int G     = 100;
  localparam int CW    = 4;
  localparam int MAXV  = (1 << CW) - 1;
  localparam int MAXC  = 40000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          sig;
  logic [CW-1:0] freq_out;
  logic          freq_valid;
  logic          overflow;
  logic          busy;

  freq_meter #(
    .GATE_CYCLES (G),
    .CNT_W       (CW),
    .SYNC_STAGES (2)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .enable        (en),
    .sig_in        (sig),
    .freq_out      (freq_out),
    .freq_valid    (freq_valid),
    .overflow      (overflow),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int f;
    int o;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  int   nchecks = 0;
  int   nerr    = 0;
  bit   armed   = 1'b0;

  // Reference model state (a window is a run of G clock cycles).
  bit lvl [MAXC];
  int p = 0;
  bit meas = 1'b0;
  int mpos = 0;
  int mcnt = 0;
  int exp_freq = 0;
  int exp_ovf = 0;
  bit exp_valid = 1'b0;
  int hcnt[$];
  int hovf[$];

  // Stimulus generator state.
  int mode = 0;
  int half = 5;
  int prob = 0;
  bit manual_lvl = 1'b0;
  int gc = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, p);
    end
  endtask

  // Behavioural model: an edge is a 0->1 of the sampled input; it lands in
  // the window cycle two clocks after it was sampled.
  initial begin
    forever begin
      bit rise;
      int raw, rovf, sum, ov;
      @(posedge clk);
      p++;
      if (p >= MAXC) begin
        $display("FAIL model_bound: got %0d expected <%0d", p, MAXC);
        $fatal(1, "cycle budget exceeded");
      end
      lvl[p] = sig;
      exp_valid = 1'b0;
      if (!rst_n) begin
        lvl[p] = 1'b0;
        if (p >= 1) lvl[p-1] = 1'b0;
        if (p >= 2) lvl[p-2] = 1'b0;
        meas = 1'b0; mpos = 0; mcnt = 0;
        exp_freq = 0; exp_ovf = 0;
        hcnt.delete(); hovf.delete();
      end else begin
        rise = (p >= 3) && lvl[p-2] && !lvl[p-3];
        if (!meas) begin
          if (en) begin
            meas = 1'b1; mpos = 0; mcnt = 0;
            hcnt.delete(); hovf.delete();
          end
        end else begin
          mcnt += int'(rise);
          if (mpos == G - 1) begin
            raw  = (mcnt > MAXV) ? MAXV : mcnt;
            rovf = (mcnt > MAXV) ? 1 : 0;
`ifdef FREQ_METER_AVG_EN
            hcnt.push_front(raw);
            hovf.push_front(rovf);
            if (hcnt.size() > 4) begin
              void'(hcnt.pop_back());
              void'(hovf.pop_back());
            end
            sum = 0; ov = 0;
            foreach (hcnt[i]) begin
              sum += hcnt[i];
              ov  |= hovf[i];
            end
            exp_freq = sum / 4;
            exp_ovf  = ov;
`else
            sum = 0; ov = 0;
            exp_freq = raw + sum;
            exp_ovf  = rovf | ov;
`endif
            exp_valid = 1'b1;
            sbq.push_back('{f: exp_freq, o: exp_ovf, cyc: p});
            mpos = 0; mcnt = 0;
            meas = en;
          end else if (!en) begin
            meas = 1'b0; mpos = 0; mcnt = 0;
          end else begin
            mpos++;
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every freq_valid and checks held outputs.
  initial begin
    forever begin
      exp_t it;
      @(negedge clk);
      if (armed) begin
        check("freq_valid", {31'd0, freq_valid}, {31'd0, exp_valid});
        if (freq_valid === 1'b1) begin
          if (sbq.size() == 0) begin
            nchecks++;
            nerr++;
            $display("FAIL sb_empty: got valid expected no pending result (cycle %0d)", p);
          end else begin
            it = sbq.pop_front();
            check("sb_freq", 32'(freq_out), it.f);
            check("sb_ovf", {31'd0, overflow}, it.o);
            check("sb_cycle", p, it.cyc);
          end
        end
        check("freq_hold", 32'(freq_out), exp_freq);
        check("ovf_hold", {31'd0, overflow}, exp_ovf);
        check("busy", {31'd0, busy}, {31'd0, meas});
      end
    end
  end

  // Input waveform generator.
  initial begin
    sig = 1'b0;
    forever begin
      @(negedge clk);
      gc++;
      case (mode)
        0: sig = 1'b0;
        1: sig = ((gc / half) % 2) != 0;
        2: if ($urandom_range(15, 0) < prob) sig = ~sig;
        3: sig = manual_lvl;
        default: sig = 1'b0;
      endcase
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Aligns on the model's window position, bounded by a cycle budget.
  task automatic wait_pos(input int target, input string nm);
    int k;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (meas && mpos == target) break;
    end
    nchecks++;
    if (k == 400) begin
      nerr++;
      $display("FAIL %s: got timeout expected window position %0d", nm, target);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    run(2);
    armed = 1'b1;
    run(1);
    check("reset_freq", 32'(freq_out), 0);
    check("reset_valid", {31'd0, freq_valid}, 0);
    rst_n = 1'b1;

    // Period-10 input: 10 edges per window.
    mode = 1; half = 5; en = 1'b1;
    run(350);
    check("steady_freq10", 32'(freq_out), 10);
    // Period-4 input: 25 edges saturate a 4-bit counter.
    half = 2;
    run(210);
    check("sat_freq", 32'(freq_out), 15);
    check("sat_ovf", {31'd0, overflow}, 1);
    // Quiet input clears the count and overflow.
    mode = 0;
    run(200);
    check("quiet_freq", 32'(freq_out), 0);
    // Enable drop mid-window, then re-enable.
    mode = 1; half = 5;
    run(150);
    wait_pos(50, "align_drop");
    en = 1'b0;
    run(20);
    en = 1'b1;
    run(250);
    // Reset pulse mid-window.
    wait_pos(70, "align_reset");
    rst_n = 1'b0;
    run(1);
    rst_n = 1'b1;
    run(1);
    check("rst_mid_freq", 32'(freq_out), 0);
    run(150);
    en = 1'b0;
    run(10);

    // Edge on the last window cycle, then an edge on a window's first cycle.
    mode = 3; manual_lvl = 1'b0; en = 1'b1;
    wait_pos(97, "align_last");
    manual_lvl = 1'b1;
    run(3);
    manual_lvl = 1'b0;
    wait_pos(98, "align_first");
    manual_lvl = 1'b1;
    run(3);
    manual_lvl = 1'b0;
    run(210);

    // Randomized segments.
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(1, 0) == 0) begin
        mode = 2; prob = $urandom_range(15, 0);
      end else begin
        mode = 1; half = $urandom_range(8, 1);
      end
      en = ($urandom_range(9, 0) != 0);
      if ($urandom_range(19, 0) == 0) begin
        rst_n = 1'b0;
        run(1);
        rst_n = 1'b1;
      end
      run($urandom_range(180, 5));
    end

    en = 1'b0;
    run(5);
    check("sb_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
